// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// LOADER_CHECKSUM_EN adds the CHECK state used for the trailing XOR checksum byte.
package loader_pkg;

  localparam int OVERSAMPLE     = 16;
  localparam int START_SAMPLE   = 8;
  localparam int BYTES_PER_WORD = 4;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {WAIT_COUNT, RECV_WORD, CHECK, DONE, ERROR} load_state_e;
`else
  typedef enum logic [2:0] {WAIT_COUNT, RECV_WORD, DONE, ERROR} load_state_e;
`endif

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, 16x oversample tick divider and bit FSM.
// Emits a one-cycle byte_valid_o or frame_err_o the cycle after the stop-bit sample.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;

  logic        meta_q, sync_q;
  logic [31:0] div_cnt_q, div_cnt_d;
  logic        tick;
  rx_state_e   state_q, state_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  assign tick = (div_cnt_q == 32'(DIV - 1));

  always_comb begin
    div_cnt_d  = tick ? 32'd0 : div_cnt_q + 32'd1;
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_d     = byte_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!sync_q) begin
          state_d    = RX_START;
          tick_cnt_d = 4'd0;
        end
      end
      // A start bit that is no longer low at its mid-point is treated as a glitch.
      RX_START: begin
        if (tick) begin
          if (tick_cnt_q == 4'(START_SAMPLE - 1)) begin
            tick_cnt_d = 4'd0;
            bit_idx_d  = 3'd0;
            state_d    = sync_q ? RX_IDLE : RX_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (tick_cnt_q == 4'(OVERSAMPLE - 1)) begin
            tick_cnt_d = 4'd0;
            shift_d    = {sync_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) state_d = RX_STOP;
            else                   bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (tick_cnt_q == 4'(OVERSAMPLE - 1)) begin
            tick_cnt_d = 4'd0;
            state_d    = RX_IDLE;
            if (sync_q) begin
              valid_d = 1'b1;
              byte_d  = shift_q;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q     <= 1'b1;
      sync_q     <= 1'b1;
      div_cnt_q  <= '0;
      state_q    <= RX_IDLE;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      meta_q     <= rx_i;
      sync_q     <= meta_q;
      div_cnt_q  <= div_cnt_d;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives a word count plus big-endian words over UART and writes them to program memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before releasing the CPU.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int MEMORY_DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx_i,
  input  logic        start_load_i,
  output logic        prog_we_o,
  output logic [31:0] prog_addr_o,
  output logic [31:0] prog_data_o,
  output logic        cpu_reset_o,
  output logic        load_done_o,
  output logic        load_error_o
);

  logic [7:0] rx_byte;
  logic       byte_valid, frame_err;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .rx_i        (uart_rx_i),
    .byte_o      (rx_byte),
    .byte_valid_o(byte_valid),
    .frame_err_o (frame_err)
  );

  load_state_e state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  word_idx_q, word_idx_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic        prog_we_q, prog_we_d;
  logic [31:0] prog_addr_q, prog_addr_d;
  logic [31:0] prog_data_q, prog_data_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    prog_we_d   = 1'b0;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    // A framing error aborts the load from anywhere except a finished image.
    if (frame_err && state_q != DONE) begin
      state_d     = ERROR;
      cpu_reset_d = 1'b1;
      error_d     = 1'b1;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        WAIT_COUNT: begin
          if (byte_valid) begin
            if (rx_byte == 8'd0 || {24'd0, rx_byte} > 32'(MEMORY_DEPTH)) begin
              state_d     = ERROR;
              cpu_reset_d = 1'b1;
              error_d     = 1'b1;
            end else begin
              state_d    = RECV_WORD;
              count_d    = rx_byte;
              word_idx_d = 8'd0;
              byte_cnt_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
              csum_d     = rx_byte;
`endif
            end
          end
        end
        RECV_WORD: begin
          if (byte_valid) begin
            shift_d    = {shift_q[23:0], rx_byte};
            byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_d     = csum_q ^ rx_byte;
`endif
            if (byte_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
              prog_we_d   = 1'b1;
              prog_addr_d = {22'd0, word_idx_q, 2'b00};
              prog_data_d = {shift_q[23:0], rx_byte};
              word_idx_d  = word_idx_q + 8'd1;
              if (word_idx_q == count_q - 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
                state_d = CHECK;
`else
                state_d = DONE;
`endif
              end
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (byte_valid) begin
            if (rx_byte == csum_q) begin
              state_d = DONE;
            end else begin
              state_d     = ERROR;
              cpu_reset_d = 1'b1;
              error_d     = 1'b1;
            end
          end
        end
`endif
        // Flags follow DONE one cycle late so the CPU is released after the final write.
        DONE: begin
          if (start_load_i) begin
            state_d     = WAIT_COUNT;
            cpu_reset_d = 1'b1;
            done_d      = 1'b0;
            error_d     = 1'b0;
          end else begin
            cpu_reset_d = 1'b0;
            done_d      = 1'b1;
          end
        end
        ERROR: begin
          if (start_load_i) begin
            state_d     = WAIT_COUNT;
            cpu_reset_d = 1'b1;
            done_d      = 1'b0;
            error_d     = 1'b0;
          end else begin
            cpu_reset_d = 1'b1;
            error_d     = 1'b1;
          end
        end
        default: state_d = ERROR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_COUNT;
      count_q     <= '0;
      word_idx_q  <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      prog_we_q   <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      prog_we_q   <= prog_we_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign prog_we_o    = prog_we_q;
  assign prog_addr_o  = prog_addr_q;
  assign prog_data_o  = prog_data_q;
  assign cpu_reset_o  = cpu_reset_q;
  assign load_done_o  = done_q;
  assign load_error_o = error_q;

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Boot-time loader upstream of the single-cycle MIPS core's program memory. It receives a program image over a UART serial line and assembles big-endian 32-bit instruction words. Each word is written into program memory through a write port. The core is held in reset until the image is complete and valid.

## Interface
Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD_RATE, 115_200, UART bit rate
- MEMORY_DEPTH, 32, program memory depth in words; maximum loadable word count

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- uart_rx_i  input  1  serial input; idle high; 8N1, LSB first
- start_load_i  input  1  one-cycle pulse; restarts loading from DONE or ERROR
- prog_we_o  output  1  program memory write strobe, one cycle per word
- prog_addr_o  output  32  byte offset of the word being written (0, 4, 8, …); the program memory base is added outside this block
- prog_data_o  output  32  instruction word
- cpu_reset_o  output  1  active-high reset for the processor; high until load succeeds
- load_done_o  output  1  high while in DONE
- load_error_o  output  1  high while in ERROR

## Operation
- Frame format: byte 0 is word count N, with 1 ≤ N ≤ MEMORY_DEPTH. It is followed by 4·N bytes, MSB first per word. Optionally a checksum byte follows (see Configuration).
- FSM states: WAIT_COUNT, RECV_WORD, CHECK, DONE, ERROR. CHECK exists only with the macro.
- After reset the FSM is in WAIT_COUNT.
- WAIT_COUNT:
  - Valid N: latch N, clear the word and byte counters, go to RECV_WORD.
  - N = 0 or N > MEMORY_DEPTH: go to ERROR.
- RECV_WORD:
  - Each byte is shifted in: data = {data[23:0], byte}.
  - On the 4th byte, pulse prog_we_o. prog_addr_o = word_index·4.
  - After the write, word_index increments and the byte counter wraps to 0.
  - After word N−1 is written: go to DONE, or to CHECK with the macro.
- DONE: cpu_reset_o = 0 and load_done_o = 1. Received bytes are ignored.
- ERROR: cpu_reset_o = 1 and load_error_o = 1. Received bytes are ignored.
- start_load_i in DONE or ERROR: go to WAIT_COUNT, reassert cpu_reset_o, clear the done and error flags. start_load_i is ignored in other states.
- Framing error (stop bit sampled low), any state except DONE: the byte is discarded and the FSM goes to ERROR.
- Reset mid-load: all state is lost. No partial write is issued after reset; words already written stay in memory.

## Timing
- Reset values: prog_we_o = 0, prog_addr_o = 0, prog_data_o = 0, cpu_reset_o = 1, load_done_o = 0, load_error_o = 0.
- Oversample tick every DIV = CLK_FREQ / (BAUD_RATE·16) cycles, integer truncated, minimum 1. The tick counter wraps DIV−1 → 0.
- uart_rx_i passes through a 2-flop synchronizer (2 cycles of latency).
- Start bit:
  - Detected on a synchronized low while the receiver is idle.
  - Re-checked at tick 8. If it is high, this is a glitch: return to idle with no byte.
- Data bits are sampled every 16 ticks after the start mid-point. The stop bit is sampled 16 ticks after bit 7.
- byte_valid pulses for one cycle, the cycle after the stop-bit sample.
- prog_we_o, prog_addr_o and prog_data_o are registered. They are valid in the cycle after the 4th byte_valid; prog_we_o is high for exactly one cycle.
- cpu_reset_o deasserts in the cycle after the final write, or after a successful CHECK. It goes high in the cycle after start_load_i.
- Word count arithmetic is 8-bit. The address is word_index·4 zero-extended to 32 bits.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - An XOR checksum byte follows the last word.
  - The running XOR covers the count byte and all data bytes.
  - In CHECK, the FSM goes to DONE if received byte == running XOR, otherwise to ERROR.
- LOADER_CHECKSUM_EN undefined: no CHECK state and no checksum byte; RECV_WORD goes straight to DONE.

## Structure
- Package loader_pkg holds:
  - FSM state enum
  - OVERSAMPLE = 16
  - START_SAMPLE = 8
  - BYTES_PER_WORD = 4
- Sub-module uart_rx_byte: synchronizer, tick divider and bit FSM (IDLE, START, DATA, STOP). Outputs byte_o[7:0], byte_valid_o, frame_err_o.
- The top level holds the load FSM, counters, shift register and output registers.

## Test plan
All tests use CLK_FREQ = 1_600_000 and BAUD_RATE = 100_000, giving DIV = 1 and 16 clocks per bit.
- Reset: assert reset for 3 cycles → cpu_reset_o = 1, prog_we_o = 0, load_done_o = 0, FSM in WAIT_COUNT.
- Load of 2 words: send 0x02, 20 08 00 05, 01 09 50 20 → two prog_we_o pulses.
  - Pulse 1: addr 0x0, data 0x20080005.
  - Pulse 2: addr 0x4, data 0x01095020.
  - cpu_reset_o falls the cycle after the 2nd pulse; load_done_o = 1.
- Count out of range: send 0x00 → ERROR, no write. Pulse start_load_i, then send 0x21 with MEMORY_DEPTH = 32 → ERROR again, no write.
- Framing error: send the 3rd data byte with its stop bit low → load_error_o = 1, no further writes, cpu_reset_o stays 1.
- Restart: from DONE, pulse start_load_i → cpu_reset_o = 1 the next cycle. Reload 1 word 0xDEADBEEF → write at addr 0x0.
- Checksum, with LOADER_CHECKSUM_EN defined: send 0x01, 11 22 33 44, then checksum 0x45 → DONE. Same image with checksum 0x00 → ERROR.
